// File: rtl/mult_div_unit_if.sv
// E-stage <-> multiply/divide unit connection: op request plus busy/hazard and HI/LO read-back.
interface mult_div_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_hazard;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, md_hazard, hi, lo);
    modport slave  (input start, op, a, b, output busy, md_hazard, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; optional MADD/MSUB ops under MDU_MADD_EN.
// state  | meaning
// S_IDLE | no op in flight, accepts start
// S_RUN  | counting down busy window, pending HI/LO commit when counter reaches 1
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic              clk,
    input logic              reset,
    mult_div_unit_if.slave   bus
);
    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q;
    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   pend_hi_q, pend_lo_q;
    logic          pend_we_q;

    logic          valid_d, multi_d, res_we_d;
    logic [63:0]   res_d;
    logic [CW-1:0] cycles_d;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   quo_s, rem_s, quo_u, rem_u;
    logic          div_ovf;

    assign prod_s  = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign prod_u  = {32'h0, bus.a} * {32'h0, bus.b};
    assign quo_s   = $signed(bus.a) / $signed(bus.b);
    assign rem_s   = $signed(bus.a) % $signed(bus.b);
    assign quo_u   = bus.a / bus.b;
    assign rem_u   = bus.a % bus.b;
    // the one signed quotient that does not fit; pin it rather than trust the divider's wrap
    assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);

    always_comb begin
        valid_d  = 1'b0;
        multi_d  = 1'b0;
        res_we_d = 1'b1;
        res_d    = '0;
        cycles_d = CW'(MULT_CYCLES);
        case (bus.op)
            OP_MULT:  begin valid_d = 1'b1; multi_d = 1'b1; res_d = prod_s; end
            OP_MULTU: begin valid_d = 1'b1; multi_d = 1'b1; res_d = prod_u; end
            OP_DIV: begin
                valid_d  = 1'b1;
                multi_d  = 1'b1;
                cycles_d = CW'(DIV_CYCLES);
                res_we_d = (bus.b != 32'h0);
                res_d    = div_ovf ? {32'h0, 32'h8000_0000} : {rem_s, quo_s};
            end
            OP_DIVU: begin
                valid_d  = 1'b1;
                multi_d  = 1'b1;
                cycles_d = CW'(DIV_CYCLES);
                res_we_d = (bus.b != 32'h0);
                res_d    = {rem_u, quo_u};
            end
            OP_MTHI, OP_MTLO: valid_d = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin valid_d = 1'b1; multi_d = 1'b1; res_d = {hi_q, lo_q} + prod_s; end
            OP_MADDU: begin valid_d = 1'b1; multi_d = 1'b1; res_d = {hi_q, lo_q} + prod_u; end
            OP_MSUB:  begin valid_d = 1'b1; multi_d = 1'b1; res_d = {hi_q, lo_q} - prod_s; end
            OP_MSUBU: begin valid_d = 1'b1; multi_d = 1'b1; res_d = {hi_q, lo_q} - prod_u; end
`else
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && valid_d) begin
                        if (multi_d) begin
                            pend_hi_q <= res_d[63:32];
                            pend_lo_q <= res_d[31:0];
                            pend_we_q <= res_we_d;
                            cnt_q     <= cycles_d;
                            busy_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else begin
                            lo_q <= bus.a;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q == CW'(1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                        if (pend_we_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.md_hazard = bus.start | busy_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; define MDU_MADD_EN to exercise the accumulate ops.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;

    mult_div_unit_if mif ();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        step();
        mif.start = 1'b0;
        mif.op    = 4'd0;
    endtask

    // counts busy cycles from the current one; bounded so a stuck busy still ends the run
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (mif.busy === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        mif.start = 1'b0;
        mif.op    = 4'd0;
        mif.a     = '0;
        mif.b     = '0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", {31'h0, mif.busy}, 32'h0);
        chk("reset_hi", mif.hi, 32'h0);
        chk("reset_lo", mif.lo, 32'h0);
        chk("reset_hazard", {31'h0, mif.md_hazard}, 32'h0);

        // MULT -3 * 5
        mif.start = 1'b1; mif.op = 4'd1; mif.a = 32'hFFFF_FFFD; mif.b = 32'd5;
        #1;
        chk("hazard_on_start", {31'h0, mif.md_hazard}, 32'h1);
        step();
        mif.start = 1'b0; mif.op = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("mult_busy_c%0d", i), {31'h0, mif.busy}, 32'h1);
            chk($sformatf("mult_hi_frozen_c%0d", i), mif.hi, 32'h0);
            step();
        end
        chk("mult_busy_done", {31'h0, mif.busy}, 32'h0);
        chk("mult_hi", mif.hi, 32'hFFFF_FFFF);
        chk("mult_lo", mif.lo, 32'hFFFF_FFF1);

        // DIVU 7/2, DIV -7/2
        issue(4'd4, 32'd7, 32'd2);
        wait_idle(n);
        chk("divu_cycles", n, 32'd10);
        chk("divu_lo", mif.lo, 32'd3);
        chk("divu_hi", mif.hi, 32'd1);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", mif.lo, 32'hFFFF_FFFD);
        chk("div_hi", mif.hi, 32'hFFFF_FFFF);

        // MTHI/MTLO then divide by zero
        issue(4'd5, 32'h1234, 32'd0);
        chk("mthi_busy", {31'h0, mif.busy}, 32'h0);
        chk("mthi_hi", mif.hi, 32'h1234);
        chk("mthi_lo_kept", mif.lo, 32'hFFFF_FFFD);
        issue(4'd6, 32'h5678, 32'd0);
        chk("mtlo_lo", mif.lo, 32'h5678);
        chk("mtlo_hi_kept", mif.hi, 32'h1234);
        issue(4'd3, 32'd99, 32'd0);
        wait_idle(n);
        chk("div0_cycles", n, 32'd10);
        chk("div0_hi", mif.hi, 32'h1234);
        chk("div0_lo", mif.lo, 32'h5678);

        // MULTU max*max with ignored starts while busy
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_busy", {31'h0, mif.busy}, 32'h1);
        mif.start = 1'b1; mif.op = 4'd6; mif.a = 32'd9;
        step();
        chk("mtlo_ignored", mif.lo, 32'h5678);
        mif.op = 4'd3; mif.a = 32'd9; mif.b = 32'd3;
        step();
        mif.start = 1'b0; mif.op = 4'd0;
        wait_idle(n);
        chk("multu_rem_cycles", n, 32'd3);
        chk("multu_hi", mif.hi, 32'hFFFF_FFFE);
        chk("multu_lo", mif.lo, 32'h0000_0001);
        step();
        chk("div_not_started", {31'h0, mif.busy}, 32'h0);

        // signed overflow divide
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("ovf_lo", mif.lo, 32'h8000_0000);
        chk("ovf_hi", mif.hi, 32'h0);

        // undefined op codes
        issue(4'd0, 32'h1, 32'h1);
        chk("op0_busy", {31'h0, mif.busy}, 32'h0);
        issue(4'd11, 32'h1, 32'h1);
        chk("op11_busy", {31'h0, mif.busy}, 32'h0);
        chk("op11_lo", mif.lo, 32'h8000_0000);

        // reset in busy cycle 3
        issue(4'd1, 32'd2, 32'd3);
        step();
        step();
        chk("pre_reset_busy", {31'h0, mif.busy}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_busy", {31'h0, mif.busy}, 32'h0);
        chk("rst_hi", mif.hi, 32'h0);
        chk("rst_lo", mif.lo, 32'h0);
        for (int i = 0; i < 5; i++) step();
        chk("no_late_commit_lo", mif.lo, 32'h0);
        chk("no_late_commit_busy", {31'h0, mif.busy}, 32'h0);

        issue(4'd6, 32'd10, 32'd0);
        issue(4'd5, 32'd0, 32'd0);
`ifdef MDU_MADD_EN
        issue(4'd7, 32'd3, 32'd4);
        wait_idle(n);
        chk("madd_cycles", n, 32'd5);
        chk("madd_lo", mif.lo, 32'd22);
        chk("madd_hi", mif.hi, 32'd0);
        issue(4'd10, 32'd1, 32'd30);
        wait_idle(n);
        chk("msubu_lo", mif.lo, 32'hFFFF_FFF8);
        chk("msubu_hi", mif.hi, 32'hFFFF_FFFF);
`else
        issue(4'd7, 32'd3, 32'd4);
        chk("madd_off_busy", {31'h0, mif.busy}, 32'h0);
        step();
        chk("madd_off_lo", mif.lo, 32'd10);
        chk("madd_off_hi", mif.hi, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
